// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

    localparam int AW_DEF         = 32;
    localparam int DW_DEF         = 32;
    localparam int MAX_DBURST_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_e;

    // Which port won the current arbitration round
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    function automatic int cnt_width(input int max_v);
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and unified-memory port of the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    // Arbiter side
    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_ready,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    // Core pipeline plus memory side
    modport master (
        output i_req, i_addr,
        input  i_rdata, i_ready,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of data grants made while a fetch is waiting.
module starve_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic         sat_o,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign sat_o = (cnt_q == W'(MAX));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && !sat_o)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between fetch and data ports; data has priority.
// MEMARB_STARVE_GUARD_EN adds a burst limit so a waiting fetch eventually wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int MAX_DBURST = MAX_DBURST_DEF
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                busy
);

    arb_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_ready_q, i_ready_d;
    logic          d_ready_q, d_ready_d;

    logic in_idle, i_elig, d_elig, i_wins, win_own;

    assign in_idle = (state_q == IDLE);
    // A port whose ready is pulsing is still showing the retired request
    assign i_elig  = bus.i_req & ~i_ready_q;
    assign d_elig  = bus.d_req & ~d_ready_q;

`ifdef MEMARB_STARVE_GUARD_EN
    localparam int CW = cnt_width(MAX_DBURST);
    logic          dc_inc, dc_clr, dc_sat;
    logic [CW-1:0] dc_cnt_unused;

    assign dc_inc = in_idle & d_elig & ~i_wins & bus.i_req;
    assign dc_clr = ~bus.i_req | (in_idle & i_wins);
    assign i_wins = i_elig & (~d_elig | dc_sat);

    starve_counter #(.MAX(MAX_DBURST), .W(CW)) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc_i (dc_inc),
        .clr_i (dc_clr),
        .sat_o (dc_sat),
        .cnt_o (dc_cnt_unused)
    );
`else
    logic unused_maxd;
    assign unused_maxd = (MAX_DBURST != 0);
    assign i_wins      = i_elig & ~d_elig;
`endif

    assign win_own = i_wins ? OWN_I : OWN_D;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_elig || d_elig) begin
                    if (win_own == OWN_D) begin
                        state_d = DBUSY;
                        addr_d  = bus.d_addr;
                        we_d    = bus.d_we;
                        wdata_d = bus.d_wdata;
                    end else begin
                        state_d = IBUSY;
                        addr_d  = bus.i_addr;
                        we_d    = 1'b0;
                    end
                end
            end
            IBUSY: begin
                if (bus.mem_ack) begin
                    i_rdata_d = bus.mem_rdata;
                    i_ready_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            DBUSY: begin
                if (bus.mem_ack) begin
                    if (!we_q) d_rdata_d = bus.mem_rdata;
                    d_ready_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
        end
    end

    // mem_req comes straight off the state register so reset drops it at once
    assign bus.mem_req   = ~in_idle;
    assign bus.mem_we    = we_q & (state_q == DBUSY);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign busy          = ~in_idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXD = 2;
`ifdef MEMARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic busy;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DBURST(MAXD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: who owns memory (0 none, 1 fetch, 2 data) and what it latched
    int          m_own;
    logic [31:0] m_addr, m_wdata, m_ird, m_drd;
    bit          m_we, m_ir, m_dr;
    int          m_dcnt;

    task automatic model_reset();
        m_own = 0; m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0;
        m_we = 0; m_ir = 0; m_dr = 0; m_dcnt = 0;
    endtask

    task automatic model_step();
        bit ie = 0, de = 0, gi = 0, gd = 0;
        bit ir_n = 0, dr_n = 0;
        if (m_own == 0) begin
            ie = bus.i_req && !m_ir;
            de = bus.d_req && !m_dr;
            gi = ie && (!de || (GUARD && m_dcnt == MAXD));
            gd = de && !gi;
            if (gd) begin
                m_own = 2; m_addr = bus.d_addr; m_we = bus.d_we; m_wdata = bus.d_wdata;
            end else if (gi) begin
                m_own = 1; m_addr = bus.i_addr; m_we = 0;
            end
        end else if (bus.mem_ack) begin
            if (m_own == 1) begin
                m_ird = bus.mem_rdata; ir_n = 1;
            end else begin
                if (!m_we) m_drd = bus.mem_rdata;
                dr_n = 1;
            end
            m_own = 0;
        end
        if (!bus.i_req || gi) m_dcnt = 0;
        else if (gd && m_dcnt < MAXD) m_dcnt++;
        m_ir = ir_n;
        m_dr = dr_n;
    endtask

    task automatic check_all();
        chk("mem_req", bus.mem_req, m_own != 0);
        chk("busy",    busy,        m_own != 0);
        chk("i_ready", bus.i_ready, m_ir);
        chk("d_ready", bus.d_ready, m_dr);
        chk("i_rdata", bus.i_rdata, m_ird);
        chk("d_rdata", bus.d_rdata, m_drd);
        if (m_own != 0) begin
            chk("mem_addr", bus.mem_addr, m_addr);
            chk("mem_we",   bus.mem_we,   (m_own == 2) && m_we);
        end
        if (m_own == 2 && m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
    endtask

    // One clock: model and DUT advance on the same edge, outputs compared 1 after
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drain(input int n);
        for (int c = 0; c < n; c++) begin
            if (m_ir) bus.i_req = 0;
            if (m_dr) bus.d_req = 0;
            bus.mem_ack   = (m_own != 0);
            bus.mem_rdata = $urandom;
            step();
        end
        bus.mem_ack = 0;
    endtask

    task automatic drive_rand();
        if (m_ir) bus.i_req = 0;
        if (m_dr) bus.d_req = 0;
        if (!bus.i_req && $urandom_range(99) < 40) begin
            bus.i_req  = 1;
            bus.i_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!bus.d_req && $urandom_range(99) < 50) begin
            bus.d_req   = 1;
            bus.d_we    = $urandom_range(1);
            bus.d_addr  = $urandom & 32'hFFFF_FFFC;
            bus.d_wdata = $urandom;
        end
        // Port inputs wandering during an access must not disturb it
        if (m_own == 2 && $urandom_range(3) == 0) begin
            bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_we = $urandom_range(1);
        end
        if (m_own == 1 && $urandom_range(3) == 0) bus.i_addr = $urandom;
        bus.mem_rdata = $urandom;
        if (m_own != 0) bus.mem_ack = ($urandom_range(2) == 0);
        else            bus.mem_ack = ($urandom_range(9) == 0);
    endtask

    int icnt_dut, icnt_mdl;

    initial begin
        reset = 0;
        bus.i_req = 0; bus.i_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ack = 0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        reset = 1;

        // Store: held values until ack, d_rdata untouched
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h84; bus.d_wdata = 32'hDEAD_BEEF;
        step();
        chk("st_we", bus.mem_we, 1);
        chk("st_addr", bus.mem_addr, 32'h84);
        chk("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        bus.d_wdata = 32'h1234_5678; bus.d_addr = 32'h88;
        step();
        chk("st_hold", bus.mem_wdata, 32'hDEAD_BEEF);
        bus.mem_ack = 1; bus.mem_rdata = 32'hFFFF_0000;
        step();
        chk("st_ready", bus.d_ready, 1);
        chk("st_rdata", bus.d_rdata, 0);
        bus.mem_ack = 0; bus.d_req = 0; bus.d_we = 0;
        step();

        // Single fetch, ack in cycle 3
        bus.i_req = 1; bus.i_addr = 32'h40;
        step();
        chk("sf_req_c1", bus.mem_req, 1);
        chk("sf_we_c1", bus.mem_we, 0);
        step();
        step();
        chk("sf_req_c3", bus.mem_req, 1);
        bus.mem_ack = 1; bus.mem_rdata = 32'h2010_0005;
        step();
        chk("sf_ready_c4", bus.i_ready, 1);
        chk("sf_rdata_c4", bus.i_rdata, 32'h2010_0005);
        chk("sf_busy_c4", busy, 0);
        bus.mem_ack = 0; bus.i_req = 0;
        step();

        // Collision: data first, fetch granted in the d_ready cycle
        bus.i_req = 1; bus.i_addr = 32'h100;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
        step();
        chk("col_own_d", bus.mem_addr, 32'h80);
        bus.mem_ack = 1; bus.mem_rdata = 32'hA5A5_0001;
        step();
        chk("col_dready_c2", bus.d_ready, 1);
        chk("col_iready_c2", bus.i_ready, 0);
        bus.mem_ack = 0; bus.d_req = 0;
        step();
        chk("col_own_i", bus.mem_addr, 32'h100);
        bus.mem_ack = 1; bus.mem_rdata = 32'hA5A5_0002;
        step();
        chk("col_iready_c4", bus.i_ready, 1);
        chk("col_irdata", bus.i_rdata, 32'hA5A5_0002);
        bus.mem_ack = 0; bus.i_req = 0;
        step();

        // Zero-wait acks, alternating ports back to back
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin bus.i_req = 1; bus.i_addr = 32'h200 + 4 * k; end
            else begin bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300 + 4 * k; end
            step();
            chk("zw_req", bus.mem_req, 1);
            bus.mem_ack = 1; bus.mem_rdata = 32'h5000 + k;
            step();
            chk("zw_ready", (k % 2 == 0) ? bus.i_ready : bus.d_ready, 1);
            chk("zw_other", (k % 2 == 0) ? bus.d_ready : bus.i_ready, 0);
            bus.mem_ack = 0; bus.i_req = 0; bus.d_req = 0;
        end
        step();

        // Both ports held continuously with 1-cycle acks
        icnt_dut = 0; icnt_mdl = 0;
        bus.i_req = 1; bus.i_addr = 32'h1000;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000;
        for (int c = 0; c < 40; c++) begin
            if (m_ir) bus.i_addr = bus.i_addr + 4;
            if (m_dr) bus.d_addr = bus.d_addr + 4;
            bus.mem_ack = (m_own != 0); bus.mem_rdata = $urandom;
            step();
            icnt_dut += int'(bus.i_ready);
            icnt_mdl += int'(m_ir);
        end
        chk("hold_icnt", icnt_dut, icnt_mdl);
        bus.i_req = 0; bus.d_req = 0;
        drain(8);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            drive_rand();
            step();
        end
        bus.i_req = 0; bus.d_req = 0;
        drain(12);

        // Asynchronous reset in the middle of a data access
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h400;
        step();
        step();
        chk("rst_pre_busy", busy, 1);
        #3 reset = 0;
        #1;
        bus.d_req = 0;
        model_reset();
        check_all();
        @(negedge clk);
        #1 reset = 1;
        bus.mem_ack = 1; bus.mem_rdata = 32'hBAD0_BAD0;
        step();
        bus.mem_ack = 0;
        step();
        chk("rst_no_dready", bus.d_ready, 0);
        chk("rst_drdata", bus.d_rdata, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
